ppu_frame_sched: RTL and testbench
==================================

PPU_FRAME_SCHED -- requirements
Module: ppu_frame_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 20000: max cycles from dma_start to dma_finish before abort (used only with PPU_FRAME_SCHED_TIMEOUT_EN).
REQ-002 SHALL have one clock and an asynchronous active-low reset, exactly as listed in REQ-003 and REQ-004.
REQ-003 SHALL provide port clk, in, 1: 50 MHz system clock.
REQ-004 SHALL provide port rst_n, in, 1: asynchronous active-low reset.
REQ-005 SHALL provide port vblank_start, in, 1: one-cycle pulse at vblank entry.
REQ-006 SHALL provide port src_addr, in, 32: VRAM source byte address from the HPS PIO.
REQ-007 SHALL provide port src_update_avail, in, 1: level; a new src_addr is available.
REQ-008 SHALL provide port src_read_rst, out, 1: one-cycle pulse; src_addr has been consumed.
REQ-009 SHALL provide port dma_src_addr, out, 32: address handed to the DMA engine.
REQ-010 SHALL provide port dma_start, out, 1: one-cycle DMA launch pulse.
REQ-011 SHALL provide port dma_finish, in, 1: one-cycle DMA completion pulse.
REQ-012 SHALL provide port dma_rdy_irq, out, 1: level IRQ to the CPU; the last DMA has ended.
REQ-013 SHALL provide ports cpu_bgscroll (in, 32), cpu_fgscroll (in, 32), cpu_enable (in, 3) and cpu_bgcolor (in, 24): live CPU PPU registers.
REQ-014 SHALL provide ports bgscroll (out, 32), fgscroll (out, 32), enable (out, 3) and bgcolor (out, 24): frame-committed PPU registers.
REQ-015 SHALL provide ports overrun (out, 1) and timeout_err (out, 1): sticky error flags.
REQ-016 SHALL provide port err_clr, in, 1: clears both sticky error flags.

Function
REQ-017 SHALL implement states IDLE and DMA_WAIT, plus a pending_valid flag and a pending_addr register.
REQ-018 In IDLE with src_update_avail=1 and src_read_rst=0 in the previous cycle, the block SHALL set pending_addr = {src_addr[31:4], 4'h0} and pending_valid=1, and pulse src_read_rst for exactly 1 cycle; a newer update SHALL overwrite the pending address (latest wins).
REQ-019 In DMA_WAIT, the block SHALL NOT consume updates (src_read_rst=0); an update held high SHALL be consumed on the first cycle back in IDLE.
REQ-020 On vblank_start in IDLE with pending_valid=1 (value before that edge), the block SHALL, on the next cycle, drive dma_src_addr=pending_addr, pulse dma_start for 1 cycle, clear pending_valid, clear dma_rdy_irq and enter DMA_WAIT.
REQ-021 An update latched in the same cycle as vblank_start with pending_valid=0 SHALL stay pending until the next vblank_start.
REQ-022 On dma_finish in DMA_WAIT, the block SHALL go to IDLE next cycle and set dma_rdy_irq=1, held until the next dma_start.
REQ-023 dma_finish in IDLE SHALL be ignored.
REQ-024 vblank_start in DMA_WAIT (including the cycle of dma_finish) SHALL NOT launch a DMA and SHALL set overrun.
REQ-025 On every vblank_start, regardless of state, the block SHALL load bgscroll, fgscroll, enable and bgcolor from the cpu_* inputs; the new values SHALL be visible one cycle later and held otherwise.
REQ-026 err_clr SHALL clear overrun and timeout_err; a set event in the same cycle as err_clr SHALL take priority.
REQ-027 The block SHALL never assert dma_start while in DMA_WAIT.

Reset
REQ-028 While rst_n=0, the block SHALL be in state IDLE with pending_valid=0, pending_addr=0, dma_src_addr=0, dma_start=0, src_read_rst=0, dma_rdy_irq=0, all committed registers 0, overrun=0, timeout_err=0 and the timeout counter at 0.
REQ-029 Reset asserted mid-DMA SHALL abandon the transfer with no dma_rdy_irq and no error flag set.

Configuration
REQ-030 With PPU_FRAME_SCHED_TIMEOUT_EN defined, a counter SHALL clear at dma_start and increment in DMA_WAIT; at TIMEOUT_CYCLES-1 without dma_finish, the block SHALL go to IDLE, set timeout_err and set dma_rdy_irq; dma_finish on that same cycle SHALL win with no error.
REQ-031 Without PPU_FRAME_SCHED_TIMEOUT_EN, the block SHALL have no counter, timeout_err SHALL be constant 0, and DMA_WAIT SHALL wait indefinitely.

Verification
REQ-032 Directed test: src_addr=0x1234_567F with update_avail high, then vblank_start -> src_read_rst 1-cycle pulse; dma_start one cycle after vblank; dma_src_addr=0x1234_5670; dma_rdy_irq=0.
REQ-033 Directed test: two updates, 0x100 then 0x200, before vblank -> two src_read_rst pulses; dma_src_addr=0x200.
REQ-034 Directed test: vblank_start during DMA_WAIT, then dma_finish -> no second dma_start; overrun=1; dma_rdy_irq=1; err_clr -> overrun=0.
REQ-035 Directed test: cpu_bgscroll=0xDEAD_BEEF changed mid-frame -> bgscroll unchanged until 1 cycle after vblank_start, then 0xDEAD_BEEF; vblank with no pending -> no dma_start.
REQ-036 Directed test: with the macro and TIMEOUT_CYCLES=16, no dma_finish -> IDLE 16 cycles after dma_start; timeout_err=1; dma_rdy_irq=1. Without the macro -> still DMA_WAIT after 1000 cycles.
REQ-037 Directed test: rst_n low for 1 cycle in DMA_WAIT -> all outputs at reset values; a subsequent vblank_start with no update -> no dma_start.

Source files
------------

// File: rtl/ppu_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module   : ppu_frame_sched
//  Brief    : Once-per-frame DMA scheduler for the PPU. Latches VRAM source
//             addresses from the HPS, launches one DMA per vblank and commits
//             the CPU-side PPU registers at every vblank.
//  Options  : PPU_FRAME_SCHED_TIMEOUT_EN enables the DMA watchdog that
//             aborts a transfer after TIMEOUT_CYCLES cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module ppu_frame_sched #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vblank_start,
  input  logic [31:0] src_addr,
  input  logic        src_update_avail,
  output logic        src_read_rst,
  output logic [31:0] dma_src_addr,
  output logic        dma_start,
  input  logic        dma_finish,
  output logic        dma_rdy_irq,
  input  logic [31:0] cpu_bgscroll,
  input  logic [31:0] cpu_fgscroll,
  input  logic [2:0]  cpu_enable,
  input  logic [23:0] cpu_bgcolor,
  output logic [31:0] bgscroll,
  output logic [31:0] fgscroll,
  output logic [2:0]  enable,
  output logic [23:0] bgcolor,
  output logic        overrun,
  output logic        timeout_err,
  input  logic        err_clr
);

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_DMA_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_pending_valid;
  logic [31:0] r_pending_addr;
  logic        r_src_read_rst;
  logic [31:0] r_dma_src_addr;
  logic        r_dma_start;
  logic        r_dma_rdy_irq;
  logic        r_overrun;
  logic [31:0] r_bgscroll;
  logic [31:0] r_fgscroll;
  logic [2:0]  r_enable;
  logic [23:0] r_bgcolor;

  logic        w_consume;
  logic        w_launch;
  logic        w_finish;
  logic        w_overrun_evt;
  logic        w_timeout;

  // Event decode; the previous-cycle read pulse blocks a double consume of one update
  assign w_consume     = (r_state == S_IDLE) && src_update_avail && !r_src_read_rst;
  assign w_launch      = (r_state == S_IDLE) && vblank_start && r_pending_valid;
  assign w_finish      = (r_state == S_DMA_WAIT) && dma_finish;
  assign w_overrun_evt = (r_state == S_DMA_WAIT) && vblank_start;

`ifdef PPU_FRAME_SCHED_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_timeout_err;

  // A finish arriving on the terminal count wins over the abort
  assign w_timeout = (r_state == S_DMA_WAIT) && !dma_finish &&
                     (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter: restarts at each launch, runs while waiting for the DMA
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (w_launch) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_DMA_WAIT) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // Sticky timeout flag; a new abort beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout) begin
      r_timeout_err <= 1'b1;
    end else if (err_clr) begin
      r_timeout_err <= 1'b0;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: launch on vblank with work pending, return on finish/abort
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_launch) w_state_nxt = S_DMA_WAIT;
      S_DMA_WAIT: if (w_finish || w_timeout) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Source-address mailbox; an update coinciding with a launch stays pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending_valid <= 1'b0;
      r_pending_addr  <= '0;
      r_src_read_rst  <= 1'b0;
    end else begin
      r_src_read_rst <= w_consume;
      if (w_consume) begin
        r_pending_addr  <= {src_addr[31:4], 4'h0};
        r_pending_valid <= 1'b1;
      end else if (w_launch) begin
        r_pending_valid <= 1'b0;
      end
    end
  end

  // DMA launch handshake and completion IRQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dma_src_addr <= '0;
      r_dma_start    <= 1'b0;
      r_dma_rdy_irq  <= 1'b0;
    end else begin
      r_dma_start <= w_launch;
      if (w_launch) begin
        r_dma_src_addr <= r_pending_addr;
        r_dma_rdy_irq  <= 1'b0;
      end else if (w_finish || w_timeout) begin
        r_dma_rdy_irq  <= 1'b1;
      end
    end
  end

  // Sticky overrun flag; a new overrun beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_overrun_evt) begin
      r_overrun <= 1'b1;
    end else if (err_clr) begin
      r_overrun <= 1'b0;
    end
  end

  // Commit the live CPU registers at every vblank so a frame sees one consistent set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bgscroll <= '0;
      r_fgscroll <= '0;
      r_enable   <= '0;
      r_bgcolor  <= '0;
    end else if (vblank_start) begin
      r_bgscroll <= cpu_bgscroll;
      r_fgscroll <= cpu_fgscroll;
      r_enable   <= cpu_enable;
      r_bgcolor  <= cpu_bgcolor;
    end
  end

  assign src_read_rst = r_src_read_rst;
  assign dma_src_addr = r_dma_src_addr;
  assign dma_start    = r_dma_start;
  assign dma_rdy_irq  = r_dma_rdy_irq;
  assign overrun      = r_overrun;
  assign bgscroll     = r_bgscroll;
  assign fgscroll     = r_fgscroll;
  assign enable       = r_enable;
  assign bgcolor      = r_bgcolor;

endmodule
`default_nettype wire

// File: tb/tb_ppu_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ppu_frame_sched
//  Brief    : Directed testbench for ppu_frame_sched. Stimulus pushes the
//             expected src_read_rst / dma_start events into queues; a monitor
//             pops and compares them whenever the DUT pulses those outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ppu_frame_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vblank_start = 1'b0;
  logic [31:0] src_addr = '0;
  logic        src_update_avail = 1'b0;
  logic        src_read_rst;
  logic [31:0] dma_src_addr;
  logic        dma_start;
  logic        dma_finish = 1'b0;
  logic        dma_rdy_irq;
  logic [31:0] cpu_bgscroll = '0;
  logic [31:0] cpu_fgscroll = '0;
  logic [2:0]  cpu_enable = '0;
  logic [23:0] cpu_bgcolor = '0;
  logic [31:0] bgscroll;
  logic [31:0] fgscroll;
  logic [2:0]  enable;
  logic [23:0] bgcolor;
  logic        overrun;
  logic        timeout_err;
  logic        err_clr = 1'b0;

  ppu_frame_sched #(.TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .vblank_start     (vblank_start),
    .src_addr         (src_addr),
    .src_update_avail (src_update_avail),
    .src_read_rst     (src_read_rst),
    .dma_src_addr     (dma_src_addr),
    .dma_start        (dma_start),
    .dma_finish       (dma_finish),
    .dma_rdy_irq      (dma_rdy_irq),
    .cpu_bgscroll     (cpu_bgscroll),
    .cpu_fgscroll     (cpu_fgscroll),
    .cpu_enable       (cpu_enable),
    .cpu_bgcolor      (cpu_bgcolor),
    .bgscroll         (bgscroll),
    .fgscroll         (fgscroll),
    .enable           (enable),
    .bgcolor          (bgcolor),
    .overrun          (overrun),
    .timeout_err      (timeout_err),
    .err_clr          (err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } dma_exp_t;

  int       exp_rd_q[$];
  dma_exp_t exp_dma_q[$];
  int       mon_rd_cyc;
  dma_exp_t mon_dma;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_rd(input int dly);
    exp_rd_q.push_back(cyc + dly);
  endtask

  task automatic expect_dma(input logic [31:0] addr, input int dly);
    dma_exp_t e;
    e.addr = addr;
    e.cyc  = cyc + dly;
    exp_dma_q.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_src_read_rst"}, {31'd0, src_read_rst}, 32'd0);
    chk({tag, "_dma_src_addr"}, dma_src_addr, 32'd0);
    chk({tag, "_dma_start"},    {31'd0, dma_start}, 32'd0);
    chk({tag, "_dma_rdy_irq"},  {31'd0, dma_rdy_irq}, 32'd0);
    chk({tag, "_bgscroll"},     bgscroll, 32'd0);
    chk({tag, "_fgscroll"},     fgscroll, 32'd0);
    chk({tag, "_enable"},       {29'd0, enable}, 32'd0);
    chk({tag, "_bgcolor"},      {8'd0, bgcolor}, 32'd0);
    chk({tag, "_overrun"},      {31'd0, overrun}, 32'd0);
    chk({tag, "_timeout_err"},  {31'd0, timeout_err}, 32'd0);
  endtask

  // Monitor: every read pulse and every DMA launch must match the next queued expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (src_read_rst) begin
        n_checks++;
        if (exp_rd_q.size() == 0) begin
          n_errors++;
          $display("FAIL rd_pulse: unexpected src_read_rst at cycle %0d", cyc);
        end else begin
          mon_rd_cyc = exp_rd_q.pop_front();
          if (mon_rd_cyc != cyc) begin
            n_errors++;
            $display("FAIL rd_pulse: src_read_rst at cycle %0d, expected cycle %0d", cyc, mon_rd_cyc);
          end
        end
      end
      if (dma_start) begin
        n_checks++;
        if (exp_dma_q.size() == 0) begin
          n_errors++;
          $display("FAIL dma_launch: unexpected dma_start at cycle %0d addr 0x%08h", cyc, dma_src_addr);
        end else begin
          mon_dma = exp_dma_q.pop_front();
          if (mon_dma.cyc != cyc || dma_src_addr !== mon_dma.addr) begin
            n_errors++;
            $display("FAIL dma_launch: got cycle %0d addr 0x%08h, expected cycle %0d addr 0x%08h",
                     cyc, dma_src_addr, mon_dma.cyc, mon_dma.addr);
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    tick(2);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick(1);

    // Basic launch with address alignment
    src_addr = 32'h1234_567F; src_update_avail = 1'b1; expect_rd(1);
    tick(1); src_update_avail = 1'b0;
    tick(2);
    vblank_start = 1'b1; expect_dma(32'h1234_5670, 1);
    tick(1); vblank_start = 1'b0;
    chk("t1_irq_at_launch", {31'd0, dma_rdy_irq}, 32'd0);
    tick(3);
    dma_finish = 1'b1; tick(1); dma_finish = 1'b0;
    chk("t1_irq_after_finish", {31'd0, dma_rdy_irq}, 32'd1);
    chk("t1_overrun", {31'd0, overrun}, 32'd0);

    // Latest update wins
    src_addr = 32'h0000_0100; src_update_avail = 1'b1; expect_rd(1);
    tick(1); src_update_avail = 1'b0; tick(1);
    src_addr = 32'h0000_0200; src_update_avail = 1'b1; expect_rd(1);
    tick(1); src_update_avail = 1'b0; tick(1);
    vblank_start = 1'b1; expect_dma(32'h0000_0200, 1);
    tick(1); vblank_start = 1'b0;
    chk("t2_irq_cleared_by_start", {31'd0, dma_rdy_irq}, 32'd0);
    tick(2);
    dma_finish = 1'b1; tick(1); dma_finish = 1'b0;
    chk("t2_irq_after_finish", {31'd0, dma_rdy_irq}, 32'd1);

    // Register commit at vblank, with no launch when nothing is pending
    cpu_bgscroll = 32'hDEAD_BEEF; cpu_fgscroll = 32'h1122_3344;
    cpu_enable = 3'b101; cpu_bgcolor = 24'hAB_CDEF;
    tick(3);
    chk("t4_bgscroll_held", bgscroll, 32'd0);
    vblank_start = 1'b1;
    chk("t4_bgscroll_vblank_cycle", bgscroll, 32'd0);
    tick(1); vblank_start = 1'b0;
    chk("t4_bgscroll_commit", bgscroll, 32'hDEAD_BEEF);
    chk("t4_fgscroll_commit", fgscroll, 32'h1122_3344);
    chk("t4_enable_commit", {29'd0, enable}, 32'd5);
    chk("t4_bgcolor_commit", {8'd0, bgcolor}, 32'h00AB_CDEF);
    cpu_bgscroll = 32'h0BAD_F00D;
    tick(2);
    chk("t4_bgscroll_hold_after", bgscroll, 32'hDEAD_BEEF);
    cpu_bgscroll = 32'hDEAD_BEEF;

    // Overrun handling and err_clr priority
    src_addr = 32'h0000_0300; src_update_avail = 1'b1; expect_rd(1);
    tick(1); src_update_avail = 1'b0; tick(1);
    src_addr = 32'h0000_0400; src_update_avail = 1'b1; vblank_start = 1'b1;
    expect_rd(1); expect_dma(32'h0000_0300, 1);
    tick(1); src_update_avail = 1'b0; vblank_start = 1'b0;
    tick(1);
    vblank_start = 1'b1; err_clr = 1'b1;
    tick(1); vblank_start = 1'b0; err_clr = 1'b0;
    chk("t3_overrun_set_beats_clr", {31'd0, overrun}, 32'd1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("t3_overrun_cleared", {31'd0, overrun}, 32'd0);
    vblank_start = 1'b1; dma_finish = 1'b1;
    tick(1); vblank_start = 1'b0; dma_finish = 1'b0;
    chk("t3_overrun_on_finish_cycle", {31'd0, overrun}, 32'd1);
    chk("t3_irq_after_finish", {31'd0, dma_rdy_irq}, 32'd1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("t3_overrun_cleared2", {31'd0, overrun}, 32'd0);
    vblank_start = 1'b1; expect_dma(32'h0000_0400, 1);
    tick(1); vblank_start = 1'b0;
    // Update held across DMA_WAIT is taken on the first IDLE cycle
    src_addr = 32'h0000_07FF; src_update_avail = 1'b1;
    tick(3);
    dma_finish = 1'b1; expect_rd(2);
    tick(1); dma_finish = 1'b0;
    tick(1); src_update_avail = 1'b0;
    chk("t3_irq_after_second_finish", {31'd0, dma_rdy_irq}, 32'd1);

    // Watchdog behaviour
    vblank_start = 1'b1; expect_dma(32'h0000_07F0, 1);
    tick(1); vblank_start = 1'b0;
`ifdef PPU_FRAME_SCHED_TIMEOUT_EN
    tick(15);
    chk("t5_irq_before_timeout", {31'd0, dma_rdy_irq}, 32'd0);
    chk("t5_tmo_before_timeout", {31'd0, timeout_err}, 32'd0);
    tick(1);
    chk("t5_irq_at_timeout", {31'd0, dma_rdy_irq}, 32'd1);
    chk("t5_tmo_at_timeout", {31'd0, timeout_err}, 32'd1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("t5_tmo_cleared", {31'd0, timeout_err}, 32'd0);
`else
    tick(1000);
    chk("t5_irq_still_waiting", {31'd0, dma_rdy_irq}, 32'd0);
    chk("t5_tmo_constant", {31'd0, timeout_err}, 32'd0);
    vblank_start = 1'b1; tick(1); vblank_start = 1'b0;
    chk("t5_still_dma_wait", {31'd0, overrun}, 32'd1);
    dma_finish = 1'b1; tick(1); dma_finish = 1'b0;
    chk("t5_irq_after_finish", {31'd0, dma_rdy_irq}, 32'd1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("t5_overrun_cleared", {31'd0, overrun}, 32'd0);
`endif

    // Reset in the middle of a DMA
    src_addr = 32'h0000_0600; src_update_avail = 1'b1; expect_rd(1);
    tick(1); src_update_avail = 1'b0; tick(1);
    vblank_start = 1'b1; expect_dma(32'h0000_0600, 1);
    tick(1); vblank_start = 1'b0;
    tick(2);
    vblank_start = 1'b1; tick(1); vblank_start = 1'b0;
    chk("t6_overrun_pre_reset", {31'd0, overrun}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("t6_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);
    dma_finish = 1'b1; tick(1); dma_finish = 1'b0;
    chk("t6_finish_in_idle_ignored", {31'd0, dma_rdy_irq}, 32'd0);
    vblank_start = 1'b1; tick(1); vblank_start = 1'b0;
    tick(2);
    chk("t6_no_launch_addr", dma_src_addr, 32'd0);
    chk("t6_irq_after_reset", {31'd0, dma_rdy_irq}, 32'd0);
    chk("t6_overrun_after_reset", {31'd0, overrun}, 32'd0);

    // Every expected event must have been observed
    tick(2);
    chk("end_rd_queue_empty", exp_rd_q.size(), 32'd0);
    chk("end_dma_queue_empty", exp_dma_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
